punc_control_mc: RTL and testbench
==================================

// Module: punc_control_mc
// PURPOSE
//  Multi-cycle LC3 control FSM for PUnC with a memory ready/request handshake.
//  Supports variable-latency memory, a wait timeout and sticky halt/error status.
//  Decodes ir, drives every datapath select/load strobe and sequences LDI/STI in two memory phases.
//  Sits beside the PUnC datapath; adds the memory wait and error behaviour the single-cycle-memory controller lacks.
// PARAMETERS
//  IR_W        16  instruction width; opcode = ir[IR_W-1 -: 4]; BR nzp = ir[IR_W-5 -: 3].
//  TIMEOUT     64  max wait cycles per memory access; 0 disables the timeout.
//  CNT_W       7   timeout counter width; must satisfy 2**CNT_W > TIMEOUT.
// PORTS
//  clk             in   1     clock, rising edge.
//  rst             in   1     reset, asynchronous assert, active-low (0 = reset).
//  ir              in   IR_W  instruction register contents.
//  cc_n/cc_z/cc_p  in   1     current condition codes.
//  mem_ready       in   1     memory completes the current access this cycle.
//  mem_req         out  1     memory access requested (held until ready).
//  mem_w_en        out  1     write strobe; valid only together with mem_ready.
//  mem_addr_sel    out  2     0 = PC, 1 = PC+off9, 2 = base+off6, 3 = indirect reg.
//  rf_w_en         out  1     register file write.
//  rf_w_addr_sel   out  1     0 = DR ir[11:9], 1 = R7.
//  rf_w_data_sel   out  2     0 = ALU, 1 = mem rdata, 2 = PC, 3 = PC+off9.
//  rf_r0_addr_sel / rf_r1_addr_sel  out  1 each  0 = ir[8:6] / ir[2:0], 1 = ir[11:9] (store source).
//  ir_ld, pc_ld, pc_clr, pc_inc  out  1 each  IR/PC control.
//  pc_ld_data_sel  out  2     0 = PC+off9, 1 = PC+off11, 2 = base reg.
//  ind_ld          out  1     load indirect address reg from mem rdata.
//  cond_ld         out  1     load condition codes.
//  cond_ld_data_sel out 1     0 = ALU, 1 = mem rdata.
//  alu_sel         out  2     0 = ADD, 1 = AND, 2 = NOT, 3 = pass A.
//  halted, mem_err, illegal_op  out  1 each  status (see below).
// BEHAVIOUR
//  Reset: state = INIT; timeout counter = 0; all outputs 0.
//  Outputs are Moore-decoded from the state, except the completion strobes, which are ANDed with mem_ready:
//   ir_ld, rf_w_en (load ops), cond_ld (load ops), mem_w_en, ind_ld.
//  INIT:  pc_clr = 1 -> FETCH.
//  FETCH: mem_req = 1, sel 0; on mem_ready: ir_ld = 1 -> DECODE.
//  DECODE: pc_inc = 1 -> EXEC.
//  EXEC by opcode:
//   ADD 0001 / AND 0101 / NOT 1001: rf_w_en, cond_ld, alu_sel 0/1/2 -> FETCH.
//   BR 0000: pc_ld iff (nzp & {cc_n,cc_z,cc_p}) != 0; nzp = 000 is a no-op -> FETCH.
//   JMP 1100: pc_ld, sel 2 -> FETCH.
//   JSR 0100: R7 <= PC (addr_sel 1, data_sel 2) and pc_ld in the same cycle;
//    sel 1 if ir[11] else 2; the RF captures the pre-load PC -> FETCH.
//   LEA 1110: rf_w_en, data_sel 3, no cond_ld -> FETCH.
//   LD 0010 / LDR 0110 / ST 0011 / STR 0111: -> MEM (addr_sel 1 / 2 / 1 / 2).
//   LDI 1010 / STI 1011: -> IND (read addr_sel 1; on ready ind_ld) -> MEM (addr_sel 3).
//   HLT 1111: -> HALT.
//   1000, 1101: illegal_op pulses 1 cycle, no other effect -> FETCH.
//  MEM: mem_req = 1; on ready, loads write the RF with data_sel 1 and cond_ld with cond sel 1;
//   stores assert mem_w_en with rf_r1_addr_sel 1 -> FETCH.
//  HALT: all strobes 0; halted = 1; exits only on reset.
//  Waits: the counter clears on entering FETCH, IND or MEM and increments each cycle mem_ready = 0.
//   If TIMEOUT != 0 and the counter reaches TIMEOUT-1 with ready still 0: -> ERR.
//  ERR: mem_err = 1 sticky, mem_req = 0, all strobes 0; exits only on reset.
//  Zero-wait latency (mem_ready = 1), cycles per instruction:
//   ALU/BR/JMP/JSR/LEA = 3; LD/ST/LDR/STR = 4; LDI/STI = 5.
//  Reset mid-access drops mem_req asynchronously; there is no partial write, because mem_w_en goes low with it.
// STRUCTURE
//  Shared package/defines: opcode constants, state encoding (4-bit), all select encodings above.
//  One sub-module: punc_mem_wait_timer (counter, clear, timeout flag).
// TESTING
//  ADD R1,R2,R3 (0x1283), ready = 1 -> ir_ld at FETCH; rf_w_en, cond_ld, alu_sel = 0 in EXEC; next FETCH 3 cycles later.
//  BRz 0x0405: cc_z = 1 -> pc_ld, sel 0; cc_z = 0 -> no pc_ld; nzp = 000 never loads.
//  LDI 0xA205 with 2 wait cycles at each access -> ind_ld on the first ready,
//   rf_w_en + cond_ld on the second, mem_addr_sel 1 then 3.
//  STR 0x7442 -> mem_w_en only in the cycle mem_ready = 1, addr_sel 2, rf_r1_addr_sel 1.
//  TIMEOUT = 4, mem_ready stuck 0 in FETCH -> ERR after 4 cycles, mem_err = 1, mem_req = 0; stays until reset.
//  HLT 0xF025 -> halted = 1; drop rst mid-MEM wait -> mem_req = 0 immediately; restart from INIT with pc_clr.

Source files
------------

// File: rtl/punc_control_mc_pkg.sv
// Shared encodings for the multi-cycle PUnC controller: opcodes, FSM states and
// every datapath select value driven by the control block.
package punc_control_mc_pkg;

  typedef enum logic [3:0] {
    OP_BR   = 4'b0000, OP_ADD  = 4'b0001, OP_LD   = 4'b0010, OP_ST   = 4'b0011,
    OP_JSR  = 4'b0100, OP_AND  = 4'b0101, OP_LDR  = 4'b0110, OP_STR  = 4'b0111,
    OP_RSV0 = 4'b1000, OP_NOT  = 4'b1001, OP_LDI  = 4'b1010, OP_STI  = 4'b1011,
    OP_JMP  = 4'b1100, OP_RSV1 = 4'b1101, OP_LEA  = 4'b1110, OP_HLT  = 4'b1111
  } opcode_e;

  typedef enum logic [3:0] {
    S_INIT, S_FETCH, S_DECODE, S_EXEC, S_IND, S_MEM, S_HALT, S_ERR
  } state_e;

  localparam logic [1:0] MEM_SEL_PC   = 2'd0;
  localparam logic [1:0] MEM_SEL_OFF9 = 2'd1;
  localparam logic [1:0] MEM_SEL_OFF6 = 2'd2;
  localparam logic [1:0] MEM_SEL_IND  = 2'd3;

  localparam logic       RF_WA_DR = 1'b0;
  localparam logic       RF_WA_R7 = 1'b1;

  localparam logic [1:0] RF_WD_ALU  = 2'd0;
  localparam logic [1:0] RF_WD_MEM  = 2'd1;
  localparam logic [1:0] RF_WD_PC   = 2'd2;
  localparam logic [1:0] RF_WD_OFF9 = 2'd3;

  localparam logic       RF_R_LOW   = 1'b0;
  localparam logic       RF_R_SRC   = 1'b1;

  localparam logic [1:0] PC_LD_OFF9  = 2'd0;
  localparam logic [1:0] PC_LD_OFF11 = 2'd1;
  localparam logic [1:0] PC_LD_BASE  = 2'd2;

  localparam logic       COND_ALU = 1'b0;
  localparam logic       COND_MEM = 1'b1;

  localparam logic [1:0] ALU_ADD  = 2'd0;
  localparam logic [1:0] ALU_AND  = 2'd1;
  localparam logic [1:0] ALU_NOT  = 2'd2;
  localparam logic [1:0] ALU_PASS = 2'd3;

  function automatic logic is_store(input opcode_e op);
    return (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
  endfunction

  // Address used in the final data phase; indirect ops use the captured pointer.
  function automatic logic [1:0] mem_addr_for(input opcode_e op);
    case (op)
      OP_LDR, OP_STR: return MEM_SEL_OFF6;
      OP_LDI, OP_STI: return MEM_SEL_IND;
      default:        return MEM_SEL_OFF9;
    endcase
  endfunction

endpackage

// File: rtl/punc_mem_wait_timer.sv
// Counts consecutive not-ready cycles of one memory access and flags when the
// wait budget is spent. A TIMEOUT of 0 never flags.
module punc_mem_wait_timer #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic timeout
);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       cnt <= '0;
    else if (clear) cnt <= '0;
    else if (inc)   cnt <= cnt + 1'b1;
  end

  assign timeout = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/punc_control_mc.sv
// Multi-cycle LC3 control FSM for PUnC with a memory ready/request handshake,
// wait timeout and sticky halt/error states.
module punc_control_mc
  import punc_control_mc_pkg::*;
#(
  parameter int IR_W    = 16,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IR_W-1:0] ir,
  input  logic            cc_n,
  input  logic            cc_z,
  input  logic            cc_p,
  input  logic            mem_ready,
  output logic            mem_req,
  output logic            mem_w_en,
  output logic [1:0]      mem_addr_sel,
  output logic            rf_w_en,
  output logic            rf_w_addr_sel,
  output logic [1:0]      rf_w_data_sel,
  output logic            rf_r0_addr_sel,
  output logic            rf_r1_addr_sel,
  output logic            ir_ld,
  output logic            pc_ld,
  output logic            pc_clr,
  output logic            pc_inc,
  output logic [1:0]      pc_ld_data_sel,
  output logic            ind_ld,
  output logic            cond_ld,
  output logic            cond_ld_data_sel,
  output logic [1:0]      alu_sel,
  output logic            halted,
  output logic            mem_err,
  output logic            illegal_op
);

  state_e  state;
  opcode_e opcode;
  logic [2:0] nzp;
  logic jsr_long, waiting, timeout;
  logic unused_ir;

  assign opcode    = opcode_e'(ir[IR_W-1 -: 4]);
  assign nzp       = ir[IR_W-5 -: 3];
  assign jsr_long  = ir[IR_W-5];
  assign unused_ir = ^ir[IR_W-8:0];
  assign waiting   = (state == S_FETCH) || (state == S_IND) || (state == S_MEM);

  punc_mem_wait_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (!waiting || mem_ready),
    .inc     (waiting && !mem_ready),
    .timeout (timeout)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_INIT;
    end else begin
      case (state)
        S_INIT:   state <= S_FETCH;
        S_FETCH:  if (mem_ready) state <= S_DECODE; else if (timeout) state <= S_ERR;
        S_DECODE: state <= S_EXEC;
        S_EXEC: begin
          case (opcode)
            OP_LD, OP_LDR, OP_ST, OP_STR: state <= S_MEM;
            OP_LDI, OP_STI:               state <= S_IND;
            OP_HLT:                       state <= S_HALT;
            default:                      state <= S_FETCH;
          endcase
        end
        S_IND:    if (mem_ready) state <= S_MEM;   else if (timeout) state <= S_ERR;
        S_MEM:    if (mem_ready) state <= S_FETCH; else if (timeout) state <= S_ERR;
        S_HALT:   state <= S_HALT;
        S_ERR:    state <= S_ERR;
        default:  state <= S_INIT;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    mem_req = 1'b0;  mem_w_en = 1'b0;  mem_addr_sel = MEM_SEL_PC;
    rf_w_en = 1'b0;  rf_w_addr_sel = RF_WA_DR;  rf_w_data_sel = RF_WD_ALU;
    rf_r0_addr_sel = RF_R_LOW;  rf_r1_addr_sel = RF_R_LOW;
    ir_ld = 1'b0;  pc_ld = 1'b0;  pc_clr = 1'b0;  pc_inc = 1'b0;
    pc_ld_data_sel = PC_LD_OFF9;  ind_ld = 1'b0;
    cond_ld = 1'b0;  cond_ld_data_sel = COND_ALU;  alu_sel = ALU_ADD;
    halted = 1'b0;  mem_err = 1'b0;  illegal_op = 1'b0;
    case (state)
      S_INIT:   pc_clr = rst;  // reset parks in INIT but must hold every output low
      S_FETCH: begin
        mem_req = 1'b1;
        ir_ld   = mem_ready;
      end
      S_DECODE: pc_inc = 1'b1;
      S_EXEC: begin
        case (opcode)
          OP_ADD, OP_AND, OP_NOT: begin
            rf_w_en = 1'b1;
            cond_ld = 1'b1;
            alu_sel = (opcode == OP_ADD) ? ALU_ADD : (opcode == OP_AND) ? ALU_AND : ALU_NOT;
          end
          OP_BR:  pc_ld = |(nzp & {cc_n, cc_z, cc_p});
          OP_JMP: begin
            pc_ld          = 1'b1;
            pc_ld_data_sel = PC_LD_BASE;
          end
          OP_JSR: begin
            // The RF write captures the current PC before the same edge reloads it.
            rf_w_en        = 1'b1;
            rf_w_addr_sel  = RF_WA_R7;
            rf_w_data_sel  = RF_WD_PC;
            pc_ld          = 1'b1;
            pc_ld_data_sel = jsr_long ? PC_LD_OFF11 : PC_LD_BASE;
          end
          OP_LEA: begin
            rf_w_en       = 1'b1;
            rf_w_data_sel = RF_WD_OFF9;
          end
          OP_RSV0, OP_RSV1: illegal_op = 1'b1;
          default: ;
        endcase
      end
      S_IND: begin
        mem_req      = 1'b1;
        mem_addr_sel = MEM_SEL_OFF9;
        ind_ld       = mem_ready;
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = mem_addr_for(opcode);
        if (is_store(opcode)) begin
          rf_r1_addr_sel = RF_R_SRC;
          mem_w_en       = mem_ready;
        end else begin
          rf_w_en          = mem_ready;
          rf_w_data_sel    = RF_WD_MEM;
          cond_ld          = mem_ready;
          cond_ld_data_sel = COND_MEM;
        end
      end
      S_HALT:  halted  = 1'b1;
      S_ERR:   mem_err = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_punc_control_mc.sv
// Self-checking bench for punc_control_mc: table-driven EXEC decode plus
// hand-written memory, timeout, halt and reset sequences through a scoreboard.
module tb_punc_control_mc;
  import punc_control_mc_pkg::*;

  localparam int IR_W = 16, TIMEOUT = 4, CNT_W = 3;

  typedef struct packed {
    logic mem_req; logic mem_w_en; logic [1:0] mem_addr_sel;
    logic rf_w_en; logic rf_w_addr_sel; logic [1:0] rf_w_data_sel;
    logic rf_r0_addr_sel; logic rf_r1_addr_sel;
    logic ir_ld; logic pc_ld; logic pc_clr; logic pc_inc; logic [1:0] pc_ld_data_sel;
    logic ind_ld; logic cond_ld; logic cond_ld_data_sel; logic [1:0] alu_sel;
    logic halted; logic mem_err; logic illegal_op;
  } ctl_t;

  typedef struct { logic [15:0] ir; logic [2:0] cc; ctl_t exp; ctl_t msk; string nm; } vec_t;
  typedef struct { ctl_t exp; ctl_t msk; string nm; } sb_t;

  logic clk = 1'b0, rst = 1'b0, cc_n = 1'b0, cc_z = 1'b0, cc_p = 1'b0, mem_ready = 1'b0;
  logic [IR_W-1:0] ir = '0;
  logic mem_req, mem_w_en, rf_w_en, rf_w_addr_sel, rf_r0_addr_sel, rf_r1_addr_sel;
  logic ir_ld, pc_ld, pc_clr, pc_inc, ind_ld, cond_ld, cond_ld_data_sel;
  logic halted, mem_err, illegal_op;
  logic [1:0] mem_addr_sel, rf_w_data_sel, pc_ld_data_sel, alu_sel;
  ctl_t act;
  int total = 0, bad = 0;
  sb_t sb_q[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  punc_control_mc #(.IR_W(IR_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .ir(ir), .cc_n(cc_n), .cc_z(cc_z), .cc_p(cc_p),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_w_en(mem_w_en),
    .mem_addr_sel(mem_addr_sel), .rf_w_en(rf_w_en), .rf_w_addr_sel(rf_w_addr_sel),
    .rf_w_data_sel(rf_w_data_sel), .rf_r0_addr_sel(rf_r0_addr_sel),
    .rf_r1_addr_sel(rf_r1_addr_sel), .ir_ld(ir_ld), .pc_ld(pc_ld), .pc_clr(pc_clr),
    .pc_inc(pc_inc), .pc_ld_data_sel(pc_ld_data_sel), .ind_ld(ind_ld), .cond_ld(cond_ld),
    .cond_ld_data_sel(cond_ld_data_sel), .alu_sel(alu_sel), .halted(halted),
    .mem_err(mem_err), .illegal_op(illegal_op)
  );

  assign act = {mem_req, mem_w_en, mem_addr_sel, rf_w_en, rf_w_addr_sel, rf_w_data_sel,
                rf_r0_addr_sel, rf_r1_addr_sel, ir_ld, pc_ld, pc_clr, pc_inc, pc_ld_data_sel,
                ind_ld, cond_ld, cond_ld_data_sel, alu_sel, halted, mem_err, illegal_op};

  function automatic ctl_t m_strb();
    ctl_t m;
    m = '0;
    m.mem_req = 1; m.mem_w_en = 1; m.rf_w_en = 1; m.ir_ld = 1; m.pc_ld = 1; m.pc_clr = 1;
    m.pc_inc = 1; m.ind_ld = 1; m.cond_ld = 1; m.halted = 1; m.mem_err = 1; m.illegal_op = 1;
    return m;
  endfunction

  function automatic ctl_t e_fetch(input logic rdy);
    ctl_t e; e = '0; e.mem_req = 1; e.mem_addr_sel = MEM_SEL_PC; e.ir_ld = rdy; return e;
  endfunction
  function automatic ctl_t m_addr();
    ctl_t m; m = m_strb(); m.mem_addr_sel = '1; return m;
  endfunction
  function automatic ctl_t e_dec();
    ctl_t e; e = '0; e.pc_inc = 1; return e;
  endfunction
  function automatic ctl_t e_alu(input logic [1:0] s);
    ctl_t e; e = '0; e.rf_w_en = 1; e.cond_ld = 1; e.alu_sel = s;
    e.rf_w_data_sel = RF_WD_ALU; e.rf_w_addr_sel = RF_WA_DR; e.cond_ld_data_sel = COND_ALU;
    return e;
  endfunction
  function automatic ctl_t m_alu();
    ctl_t m; m = m_strb(); m.alu_sel = '1; m.rf_w_data_sel = '1; m.rf_w_addr_sel = 1;
    m.cond_ld_data_sel = 1; return m;
  endfunction
  function automatic ctl_t e_pc(input logic ld, input logic [1:0] s);
    ctl_t e; e = '0; e.pc_ld = ld; e.pc_ld_data_sel = s; return e;
  endfunction
  function automatic ctl_t m_pc();
    ctl_t m; m = m_strb(); m.pc_ld_data_sel = '1; return m;
  endfunction
  function automatic ctl_t e_jsr(input logic [1:0] s);
    ctl_t e; e = e_pc(1'b1, s); e.rf_w_en = 1; e.rf_w_addr_sel = RF_WA_R7;
    e.rf_w_data_sel = RF_WD_PC; return e;
  endfunction
  function automatic ctl_t m_rfpc();
    ctl_t m; m = m_pc(); m.rf_w_addr_sel = 1; m.rf_w_data_sel = '1; return m;
  endfunction
  function automatic ctl_t e_lea();
    ctl_t e; e = '0; e.rf_w_en = 1; e.rf_w_data_sel = RF_WD_OFF9; e.rf_w_addr_sel = RF_WA_DR;
    return e;
  endfunction
  function automatic ctl_t e_ill();
    ctl_t e; e = '0; e.illegal_op = 1; return e;
  endfunction
  function automatic ctl_t e_ind(input logic rdy);
    ctl_t e; e = '0; e.mem_req = 1; e.mem_addr_sel = MEM_SEL_OFF9; e.ind_ld = rdy; return e;
  endfunction
  function automatic ctl_t e_ld(input logic rdy, input logic [1:0] a);
    ctl_t e; e = '0; e.mem_req = 1; e.mem_addr_sel = a; e.rf_w_en = rdy; e.cond_ld = rdy;
    e.rf_w_data_sel = RF_WD_MEM; e.cond_ld_data_sel = COND_MEM; return e;
  endfunction
  function automatic ctl_t m_ld(input logic rdy);
    ctl_t m; m = m_addr();
    if (rdy) begin m.rf_w_data_sel = '1; m.cond_ld_data_sel = 1; end
    return m;
  endfunction
  function automatic ctl_t e_st(input logic rdy, input logic [1:0] a);
    ctl_t e; e = '0; e.mem_req = 1; e.mem_addr_sel = a; e.mem_w_en = rdy;
    e.rf_r1_addr_sel = RF_R_SRC; e.rf_r0_addr_sel = RF_R_LOW; return e;
  endfunction
  function automatic ctl_t m_st();
    ctl_t m; m = m_addr(); m.rf_r1_addr_sel = 1; m.rf_r0_addr_sel = 1; return m;
  endfunction
  function automatic ctl_t e_stat(input logic h, input logic err);
    ctl_t e; e = '0; e.halted = h; e.mem_err = err; return e;
  endfunction
  function automatic ctl_t e_init();
    ctl_t e; e = '0; e.pc_clr = 1; return e;
  endfunction

  function automatic vec_t mk(input logic [15:0] i, input logic [2:0] c, input ctl_t e,
                              input ctl_t m, input string n);
    vec_t v; v.ir = i; v.cc = c; v.exp = e; v.msk = m; v.nm = n; return v;
  endfunction

  task automatic check(input string nm, input ctl_t a, input ctl_t e, input ctl_t m);
    total++;
    if (((a ^ e) & m) != '0) begin
      bad++;
      $display("FAIL %s: got %h want %h (compared bits %h)", nm, a, e, m);
    end
  endtask

  // One controller cycle: drive ready, queue the expectation, compare mid-cycle.
  task automatic step(input logic rdy, input ctl_t e, input ctl_t m, input string nm);
    sb_t s;
    mem_ready = rdy;
    s.exp = e; s.msk = m; s.nm = nm;
    sb_q.push_back(s);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: scoreboard empty at sample", nm);
    end else begin
      s = sb_q.pop_front();
      check(s.nm, act, s.exp, s.msk);
    end
    @(posedge clk); #1;
  endtask

  task automatic front(input logic [15:0] i, input string nm);
    ir = i;
    step(1'b1, e_fetch(1'b1), m_addr(), {nm, "_fetch"});
    step(1'b1, e_dec(), m_strb(), {nm, "_decode"});
  endtask

  task automatic do_reset(input string nm);
    rst = 1'b0;
    #2;
    check({nm, "_all_zero"}, act, '0, '1);
    @(posedge clk); #1;
    rst = 1'b1;
    step(1'b0, e_init(), m_strb(), {nm, "_init"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl.push_back(mk(16'h1283, 3'b000, e_alu(ALU_ADD),            m_alu(),  "add"));
    tbl.push_back(mk(16'h5283, 3'b000, e_alu(ALU_AND),            m_alu(),  "and"));
    tbl.push_back(mk(16'h927F, 3'b000, e_alu(ALU_NOT),            m_alu(),  "not"));
    tbl.push_back(mk(16'h0405, 3'b010, e_pc(1'b1, PC_LD_OFF9),    m_pc(),   "brz_taken"));
    tbl.push_back(mk(16'h0405, 3'b100, e_pc(1'b0, PC_LD_OFF9),    m_strb(), "brz_not_taken"));
    tbl.push_back(mk(16'h0005, 3'b111, e_pc(1'b0, PC_LD_OFF9),    m_strb(), "br_nzp0"));
    tbl.push_back(mk(16'h0A05, 3'b001, e_pc(1'b1, PC_LD_OFF9),    m_pc(),   "brnp_taken"));
    tbl.push_back(mk(16'hC080, 3'b000, e_pc(1'b1, PC_LD_BASE),    m_pc(),   "jmp"));
    tbl.push_back(mk(16'h4802, 3'b000, e_jsr(PC_LD_OFF11),        m_rfpc(), "jsr"));
    tbl.push_back(mk(16'h4080, 3'b000, e_jsr(PC_LD_BASE),         m_rfpc(), "jsrr"));
    tbl.push_back(mk(16'hE205, 3'b000, e_lea(),                   m_rfpc(), "lea"));
    tbl.push_back(mk(16'h8000, 3'b000, e_ill(),                   m_strb(), "illegal_8"));
    tbl.push_back(mk(16'hD000, 3'b000, e_ill(),                   m_strb(), "illegal_d"));

    @(posedge clk); #1;
    do_reset("reset");

    foreach (tbl[i]) begin
      {cc_n, cc_z, cc_p} = tbl[i].cc;
      front(tbl[i].ir, tbl[i].nm);
      step(1'b1, tbl[i].exp, tbl[i].msk, {tbl[i].nm, "_exec"});
    end
    {cc_n, cc_z, cc_p} = 3'b000;

    // LD zero-wait: 4 cycles, then FETCH again.
    front(16'h2205, "ld");
    step(1'b1, '0, m_strb(), "ld_exec");
    step(1'b1, e_ld(1'b1, MEM_SEL_OFF9), m_ld(1'b1), "ld_mem");

    // STR with two waits: write strobe only on the ready cycle.
    front(16'h7442, "str");
    step(1'b0, '0, m_strb(), "str_exec");
    step(1'b0, e_st(1'b0, MEM_SEL_OFF6), m_st(), "str_wait1");
    step(1'b0, e_st(1'b0, MEM_SEL_OFF6), m_st(), "str_wait2");
    step(1'b1, e_st(1'b1, MEM_SEL_OFF6), m_st(), "str_done");

    // LDI with two waits on each access.
    front(16'hA205, "ldi");
    step(1'b0, '0, m_strb(), "ldi_exec");
    step(1'b0, e_ind(1'b0), m_addr(), "ldi_ind_wait1");
    step(1'b0, e_ind(1'b0), m_addr(), "ldi_ind_wait2");
    step(1'b1, e_ind(1'b1), m_addr(), "ldi_ind_done");
    step(1'b0, e_ld(1'b0, MEM_SEL_IND), m_ld(1'b0), "ldi_mem_wait1");
    step(1'b0, e_ld(1'b0, MEM_SEL_IND), m_ld(1'b0), "ldi_mem_wait2");
    step(1'b1, e_ld(1'b1, MEM_SEL_IND), m_ld(1'b1), "ldi_mem_done");

    // STI zero-wait: 5 cycles.
    front(16'hB205, "sti");
    step(1'b1, '0, m_strb(), "sti_exec");
    step(1'b1, e_ind(1'b1), m_addr(), "sti_ind");
    step(1'b1, e_st(1'b1, MEM_SEL_IND), m_st(), "sti_mem");

    // Ready arriving on the last allowed wait cycle must not error.
    ir = 16'h1283;
    for (int i = 0; i < TIMEOUT - 1; i++) step(1'b0, e_fetch(1'b0), m_addr(), "edge_fetch_wait");
    step(1'b1, e_fetch(1'b1), m_addr(), "edge_fetch_ready");
    step(1'b1, e_dec(), m_strb(), "edge_decode");
    step(1'b1, e_alu(ALU_ADD), m_alu(), "edge_exec");

    // HLT: sticky until reset.
    front(16'hF025, "hlt");
    step(1'b1, '0, m_strb(), "hlt_exec");
    for (int i = 0; i < 3; i++) step(i[0], e_stat(1'b1, 1'b0), m_strb(), "halt_hold");
    do_reset("halt_reset");

    // Reset mid-MEM wait: request and write strobe must drop at once.
    front(16'h3205, "st_rst");
    step(1'b0, '0, m_strb(), "st_rst_exec");
    mem_ready = 1'b0;
    #2;
    check("st_rst_req_before", act, e_st(1'b0, MEM_SEL_OFF9), m_st());
    mem_ready = 1'b1;
    rst = 1'b0;
    #1;
    check("st_rst_drop", act, '0, '1);
    @(posedge clk); #1;
    rst = 1'b1;
    step(1'b0, e_init(), m_strb(), "st_rst_init");

    // Memory never answers in FETCH: error after TIMEOUT cycles, sticky.
    for (int i = 0; i < TIMEOUT; i++) step(1'b0, e_fetch(1'b0), m_addr(), "tmo_fetch_wait");
    for (int i = 0; i < 3; i++) step(1'b1, e_stat(1'b0, 1'b1), m_strb(), "tmo_err_hold");
    do_reset("err_reset");
    step(1'b1, e_fetch(1'b1), m_addr(), "post_err_fetch");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
